// File: rtl/vend_controller.sv
// vend_controller: credit-and-dispense controller for the vending machine.
// Consumes one-cycle button/coin ticks, tracks credit, pulses dispense on an
// accepted sale and pays change one coin per cycle, largest coin first.
module vend_controller #(
  parameter int PRICE      = 35,
  parameter int MAX_CREDIT = 95,
  parameter int CREDIT_W   = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin5_tick,
  input  logic                coin10_tick,
  input  logic                coin25_tick,
  input  logic                sel_tick,
  input  logic                cancel_tick,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic                ret25,
  output logic                ret10,
  output logic                ret5,
  output logic                coin_reject,
  output logic                insufficient,
  output logic                busy
);

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    DISPENSE = 2'd1,
    CHANGE   = 2'd2
  } state_t;

  // One extra bit of headroom so credit + coins can be compared against the
  // ceiling without wrapping.
  localparam logic [CREDIT_W:0] PRICE_W = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W:0] MAX_W   = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W:0] C5      = (CREDIT_W+1)'(5);
  localparam logic [CREDIT_W:0] C10     = (CREDIT_W+1)'(10);
  localparam logic [CREDIT_W:0] C25     = (CREDIT_W+1)'(25);

  state_t              state_reg, state_next;
  logic [CREDIT_W-1:0] credit_reg, credit_next;
  logic                coin_reject_reg, coin_reject_next;
  logic                insufficient_reg, insufficient_next;

  logic [CREDIT_W:0]   credit_ext;
  logic [CREDIT_W:0]   coin_sum;
  logic [CREDIT_W:0]   credit_plus;
  logic [CREDIT_W:0]   change_coin;
  logic [CREDIT_W:0]   credit_minus_change;
  logic [CREDIT_W:0]   credit_minus_price;
  logic                any_coin;
  logic                in_change;

  assign credit_ext          = {1'b0, credit_reg};
  assign any_coin            = coin5_tick | coin10_tick | coin25_tick;
  assign coin_sum            = (coin5_tick  ? C5  : '0)
                             + (coin10_tick ? C10 : '0)
                             + (coin25_tick ? C25 : '0);
  assign credit_plus         = credit_ext + coin_sum;
  assign credit_minus_price  = credit_ext - PRICE_W;
  assign credit_minus_change = credit_ext - change_coin;

  // Change coins are decoded straight from state and remaining credit.
  assign in_change   = (state_reg == CHANGE);
  assign ret25       = in_change && (credit_ext >= C25);
  assign ret10       = in_change && (credit_ext <  C25) && (credit_ext >= C10);
  assign ret5        = in_change && (credit_ext <  C10) && (credit_ext >= C5);
  assign change_coin = ret25 ? C25 : (ret10 ? C10 : (ret5 ? C5 : '0));

  assign credit       = credit_reg;
  assign dispense     = (state_reg == DISPENSE);
  assign busy         = (state_reg != COLLECT);
  assign coin_reject  = coin_reject_reg;
  assign insufficient = insufficient_reg;

  // State, credit and the two refusal pulses update on every edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= COLLECT;
      credit_reg       <= '0;
      coin_reject_reg  <= 1'b0;
      insufficient_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      credit_reg       <= credit_next;
      coin_reject_reg  <= coin_reject_next;
      insufficient_reg <= insufficient_next;
    end
  end

  // Next-state logic: in COLLECT cancel beats select beats coins; coins that
  // share an edge with cancel/select or arrive while busy are refused.
  always_comb begin
    state_next        = state_reg;
    credit_next       = credit_reg;
    coin_reject_next  = 1'b0;
    insufficient_next = 1'b0;
    case (state_reg)
      COLLECT: begin
        if (cancel_tick) begin
          coin_reject_next = any_coin;
          if (credit_reg != '0) state_next = CHANGE;
        end else if (sel_tick) begin
          coin_reject_next = any_coin;
          if (credit_ext >= PRICE_W) begin
            credit_next = credit_minus_price[CREDIT_W-1:0];
            state_next  = DISPENSE;
          end else begin
            insufficient_next = 1'b1;
          end
        end else if (any_coin) begin
          if (credit_plus <= MAX_W) credit_next = credit_plus[CREDIT_W-1:0];
          else coin_reject_next = 1'b1;
        end
      end
      DISPENSE: begin
        coin_reject_next = any_coin;
        state_next       = (credit_reg != '0) ? CHANGE : COLLECT;
      end
      CHANGE: begin
        coin_reject_next = any_coin;
        credit_next      = credit_minus_change[CREDIT_W-1:0];
        if (credit_minus_change == '0) state_next = COLLECT;
      end
      default: begin
        state_next  = COLLECT;
        credit_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: table-driven vectors with a scoreboard queue. Each
// vector drives one edge of ticks; the expected outputs for the following
// cycle are queued when driven and popped for comparison after the edge.
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       rst, coin5_tick, coin10_tick, coin25_tick, sel_tick, cancel_tick;
  logic [6:0] credit;
  logic       dispense, ret25, ret10, ret5, coin_reject, insufficient, busy;

  vend_controller #(.PRICE(35), .MAX_CREDIT(95), .CREDIT_W(7)) dut (
    .clk(clk), .rst(rst),
    .coin5_tick(coin5_tick), .coin10_tick(coin10_tick), .coin25_tick(coin25_tick),
    .sel_tick(sel_tick), .cancel_tick(cancel_tick),
    .credit(credit), .dispense(dispense),
    .ret25(ret25), .ret10(ret10), .ret5(ret5),
    .coin_reject(coin_reject), .insufficient(insufficient), .busy(busy)
  );

  always #5 clk = ~clk;

  // Input bits {rst, cancel, sel, c25, c10, c5}
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] C5   = 6'b000001;
  localparam logic [5:0] C10  = 6'b000010;
  localparam logic [5:0] C25  = 6'b000100;
  localparam logic [5:0] SEL  = 6'b001000;
  localparam logic [5:0] CAN  = 6'b010000;
  localparam logic [5:0] RST  = 6'b100000;
  // Output flags {dispense, ret25, ret10, ret5, coin_reject, insufficient, busy}
  localparam logic [6:0] F0   = 7'b0000000;
  localparam logic [6:0] DSP  = 7'b1000000;
  localparam logic [6:0] R25  = 7'b0100000;
  localparam logic [6:0] R10  = 7'b0010000;
  localparam logic [6:0] R5   = 7'b0001000;
  localparam logic [6:0] REJ  = 7'b0000100;
  localparam logic [6:0] INS  = 7'b0000010;
  localparam logic [6:0] BSY  = 7'b0000001;

  typedef struct {
    logic [5:0]  ins;
    logic [13:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [13:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          txn      = 0;

  task automatic add(input logic [5:0] ins, input int cr, input logic [6:0] flags);
    vec_t v;
    v.ins = ins;
    v.exp = {7'(cr), flags};
    vecs.push_back(v);
  endtask

  // Drive one edge of ticks, queue the expectation, compare after the edge.
  task automatic step(input logic [5:0] ins, input logic [13:0] exp);
    logic [13:0] act, want;
    @(negedge clk);
    {rst, cancel_tick, sel_tick, coin25_tick, coin10_tick, coin5_tick} = ins;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    act = {credit, dispense, ret25, ret10, ret5, coin_reject, insufficient, busy};
    n_checks++;
    txn++;
    if (exp_q.size() == 0) begin
      $display("FAIL txn%0d scoreboard: empty queue, got %h", txn, act);
    end else begin
      want = exp_q.pop_front();
      if (act === want) begin
        n_pass++;
        $display("txn %0d in=%b credit=%0d flags=%b ok", txn, ins, act[13:7], act[6:0]);
      end else begin
        $display("FAIL txn%0d outputs: got credit=%0d flags=%b, expected credit=%0d flags=%b",
                 txn, act[13:7], act[6:0], want[13:7], want[6:0]);
      end
    end
  endtask

  initial begin
    {rst, cancel_tick, sel_tick, coin25_tick, coin10_tick, coin5_tick} = '0;

    // Reset and a sale with 10 cents change
    add(RST, 0, F0);
    add(C25, 25, F0);
    add(C10, 35, F0);
    add(C10, 45, F0);
    add(SEL, 10, DSP | BSY);
    add(NONE, 10, R10 | BSY);
    add(NONE, 0, F0);
    // Cancel 40 cents: 25, 10, 5
    add(C25, 25, F0);
    add(C10, 35, F0);
    add(C5, 40, F0);
    add(CAN, 40, R25 | BSY);
    add(NONE, 15, R10 | BSY);
    add(NONE, 5, R5 | BSY);
    add(NONE, 0, F0);
    // Credit ceiling
    add(C25, 25, F0);
    add(C25, 50, F0);
    add(C25, 75, F0);
    add(C10, 85, F0);
    add(C5, 90, F0);
    add(C10, 90, REJ);
    add(C5, 95, F0);
    add(C5, 95, REJ);
    add(CAN, 95, R25 | BSY);
    add(NONE, 70, R25 | BSY);
    add(NONE, 45, R25 | BSY);
    add(NONE, 20, R10 | BSY);
    add(NONE, 10, R10 | BSY);
    add(NONE, 0, F0);
    // Insufficient credit, simultaneous coins
    add(C10, 10, F0);
    add(C10, 20, F0);
    add(SEL, 20, INS);
    add(C10 | C25, 55, F0);
    add(CAN, 55, R25 | BSY);
    add(NONE, 30, R25 | BSY);
    add(NONE, 5, R5 | BSY);
    add(NONE, 0, F0);
    // Cancel with zero credit; coin with cancel refused
    add(CAN, 0, F0);
    add(CAN | C5, 0, REJ);
    // Exact price with a coin on the select edge, coin during DISPENSE
    add(C25, 25, F0);
    add(C10, 35, F0);
    add(SEL | C25, 0, DSP | REJ | BSY);
    add(C5, 0, REJ);
    add(NONE, 0, F0);

    foreach (vecs[i]) step(vecs[i].ins, vecs[i].exp);

    // Reset in the middle of a 40-cent change sequence forfeits the rest
    step(C25,  {7'd25, F0});
    step(C10,  {7'd35, F0});
    step(C5,   {7'd40, F0});
    step(CAN,  {7'd40, R25 | BSY});
    step(NONE, {7'd15, R10 | BSY});
    step(RST,  {7'd0,  F0});
    step(NONE, {7'd0,  F0});
    step(NONE, {7'd0,  F0});
    // Select and cancel on the same edge: cancel wins
    step(C25,  {7'd25, F0});
    step(C10,  {7'd35, F0});
    step(SEL | CAN, {7'd35, R25 | BSY});
    step(NONE, {7'd10, R10 | BSY});
    step(NONE, {7'd0,  F0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
# vend_controller

Credit-and-dispense controller for the vending machine. It sits directly downstream of the per-button edge detectors and consumes their one-cycle tick pulses: coin inserts (5/10/25), product select and cancel. It keeps the running credit, fires a one-cycle dispense pulse when a paid selection is accepted, and returns change as a sequence of one-coin-per-cycle pulses, largest coin first.

## Interface
- PRICE, 35: product price in cents; multiple of 5, ≤ MAX_CREDIT.
- MAX_CREDIT, 95: credit ceiling in cents; multiple of 5, < 2^CREDIT_W.
- CREDIT_W, 7: width of credit register.
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- coin5_tick, coin10_tick, coin25_tick  in  1 each  one-cycle coin pulses from edge detectors.
- sel_tick  in  1  one-cycle select pulse.
- cancel_tick  in  1  one-cycle cancel pulse.
- credit  out  CREDIT_W  current credit in cents.
- dispense  out  1  high exactly one cycle per accepted sale.
- ret25, ret10, ret5  out  1 each  change-coin pulses; at most one high per cycle.
- coin_reject  out  1  one-cycle pulse: coins from the previous edge were refused.
- insufficient  out  1  one-cycle pulse: select at the previous edge was refused for low credit.
- busy  out  1  high whenever state ≠ COLLECT.

## Operation
- States: COLLECT, DISPENSE, CHANGE. Reset → COLLECT, credit=0, all outputs 0.
- COLLECT, per edge, priority cancel > sel > coins:
  - cancel: credit>0 → CHANGE, credit kept. credit=0 → stay, no action.
  - sel, credit≥PRICE: credit ← credit−PRICE, → DISPENSE.
  - sel, credit<PRICE: stay, insufficient pulses next cycle, credit unchanged.
  - Coins only, no cancel/sel: sum = 5·coin5 + 10·coin10 + 25·coin25 (simultaneous coins summed).
    - credit+sum ≤ MAX_CREDIT: credit ← credit+sum.
    - Otherwise all coins that edge refused, credit unchanged, coin_reject pulses.
  - Any coin tick in the same edge as cancel or sel is refused, coin_reject pulses.
- DISPENSE, one cycle: dispense=1. Next edge: credit>0 → CHANGE, else → COLLECT.
- CHANGE:
  - ret25 = credit≥25; else ret10 = credit≥10; else ret5 = credit≥5. Decoded from state and credit.
  - Each edge subtracts the coin shown. When credit reaches 0 → COLLECT.
  - Credit is always a multiple of 5, so CHANGE always terminates.
- Coin ticks in DISPENSE or CHANGE: refused, coin_reject pulses. sel/cancel in DISPENSE or CHANGE: ignored silently.
- Register widths: arithmetic on credit uses CREDIT_W+1 bits for the overflow compare; credit never exceeds MAX_CREDIT and never goes negative.

## Timing
- Ticks are sampled at posedge t. credit, state, coin_reject and insufficient reflect that edge from t+1.
- Sale latency: sel at edge t → dispense high in cycle t+1 (credit already reduced) → first change coin in cycle t+2 if credit>0.
- Change of N coins occupies N cycles. busy falls in the cycle after the final coin.
- dispense, ret*, busy: Moore outputs decoded from state/credit.
- coin_reject, insufficient: registered one-cycle pulses.
- rst asserted at any edge, including mid-DISPENSE or mid-CHANGE: next cycle state=COLLECT, credit=0, every output 0. Pending change is forfeited.

## Test plan
- Reset, then coin25, coin10, coin10 on separate edges → credit 25, 35, 45. sel → dispense one cycle with credit=10; next cycle ret10=1; following cycle credit=0, busy=0.
- credit 40, cancel → ret25 (credit 15), ret10 (credit 5), ret5 (credit 0) on three consecutive cycles, then COLLECT.
- credit 90, coin10 → coin_reject pulse, credit stays 90. Then coin5 → credit 95. Then coin5 → reject.
- credit 20, sel → insufficient pulse, no dispense, credit 20. coin10+coin25 same edge → credit 55.
- sel and coin25 on the same edge with credit 35 → dispense, coin_reject pulse, credit 0, no change cycles. coin5 during DISPENSE → coin_reject.
- rst during second change cycle of a 40-cent cancel → next cycle credit=0, ret*=0, busy=0. No further coins emitted.
